// File: rtl/phase_tx_pkg.sv
// Shared definitions for the phase-word serial transmitter.
// Holds the default word width, frame prefix/trailer constants, the frame
// length helper and the scheduler FSM state encoding.
// Optional feature macro: PHASE_TX_PARITY_EN adds an even-parity bit after
// the data field.
package phase_tx_pkg;

    localparam int unsigned NUM_SIZE_DEF = 7;

    // Frame framing bits, transmitted MSB first.
    localparam logic [1:0] FRAME_PREFIX  = 2'b01;
    localparam logic [1:0] FRAME_TRAILER = 2'b10;

`ifdef PHASE_TX_PARITY_EN
    localparam int unsigned PARITY_BITS = 1;
`else
    localparam int unsigned PARITY_BITS = 0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    // Total bits on the line for one word: prefix + data + parity + trailer.
    function automatic int unsigned frame_len(input int unsigned num_size);
        return 2 + num_size + PARITY_BITS + 2;
    endfunction

endpackage

// File: rtl/phase_bit_timer.sv
// Bit-period timer for the serial transmitter.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   restart     : force the count back to zero (asserted while loading a frame)
//   en          : advance the count
//   tick_c      : high on the last cycle of a bit period
//   pre_tick_c  : high on the second-to-last cycle of a bit period
module phase_bit_timer #(
    parameter int unsigned BIT_PERIOD = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic en,
    output logic tick_c,
    output logic pre_tick_c
);

    localparam int unsigned CNT_W = $clog2(BIT_PERIOD);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_c     = (cnt_q == CNT_W'(BIT_PERIOD - 1));
    assign pre_tick_c = (cnt_q == CNT_W'(BIT_PERIOD - 2));

    // Count wraps at BIT_PERIOD-1.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/phase_word_tx_sched.sv
// Round-robin scheduler that serialises phase-delay words from several
// requesters onto one serial line feeding the Decoder.
// Frame (MSB first): 0,1, data word MSB first, [even parity], 1,0; each bit is
// held BIT_PERIOD cycles, followed by GAP_BITS idle-low bit periods.
// Macro PHASE_TX_PARITY_EN: when defined, an even-parity bit is inserted.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   req         : per-requester send request, held until ack
//   req_data    : requester i word at [i*NUM_SIZE +: NUM_SIZE]
//   ack         : one-cycle pulse when a requester's word is captured
//   grant_idx   : requester whose frame is on the line (held until next load)
//   busy        : high whenever the scheduler is not idle
//   ser_out     : serial line, idles low
//   frame_done  : one-cycle pulse on the last cycle of the last frame bit
module phase_word_tx_sched
    import phase_tx_pkg::*;
#(
    parameter int unsigned NUM_SIZE   = NUM_SIZE_DEF,
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned BIT_PERIOD = 1024,
    parameter int unsigned GAP_BITS   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*NUM_SIZE-1:0]  req_data,
    output logic [NUM_REQ-1:0]           ack,
    output logic [$clog2(NUM_REQ)-1:0]   grant_idx,
    output logic                         busy,
    output logic                         ser_out,
    output logic                         frame_done
);

    localparam int unsigned IDX_W     = $clog2(NUM_REQ);
    localparam int unsigned FRAME_LEN = frame_len(NUM_SIZE);
    localparam int unsigned MAX_CNT   = (FRAME_LEN > GAP_BITS) ? FRAME_LEN : GAP_BITS;
    localparam int unsigned BC_W      = $clog2(MAX_CNT + 1);
    localparam int unsigned GAP_LAST  = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(FRAME_LEN - 1);
    localparam logic [BC_W-1:0] LAST_GAP = BC_W'(GAP_LAST);

    tx_state_e              state_q, state_d;
    logic [IDX_W-1:0]       winner_q, winner_d;
    logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic [FRAME_LEN-1:0]   shift_q, shift_d;
    logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                   ser_out_q, ser_out_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic                   frame_done_q, frame_done_d;
    logic                   busy_q, busy_d;

    logic                   tick_c;
    logic                   pre_tick_c;
    logic [IDX_W-1:0]       rr_winner_c;
    logic [NUM_SIZE-1:0]    word_sel_c;
    logic [FRAME_LEN-1:0]   frame_w_c;

    phase_bit_timer #(
        .BIT_PERIOD (BIT_PERIOD)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .restart    (state_q == ST_LOAD),
        .en         ((state_q == ST_SEND) || (state_q == ST_GAP)),
        .tick_c     (tick_c),
        .pre_tick_c (pre_tick_c)
    );

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int unsigned cand;
        logic        found;
        cand        = 0;
        found       = 1'b0;
        rr_winner_c = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = (32'(last_grant_q) + i) % NUM_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                rr_winner_c = IDX_W'(cand);
            end
        end
    end

    // Word of the pending winner, assembled into a full frame.
    always_comb begin
        word_sel_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner_q == IDX_W'(i)) begin
                word_sel_c = req_data[i*NUM_SIZE +: NUM_SIZE];
            end
        end
`ifdef PHASE_TX_PARITY_EN
        frame_w_c = {FRAME_PREFIX, word_sel_c, ^word_sel_c, FRAME_TRAILER};
`else
        frame_w_c = {FRAME_PREFIX, word_sel_c, FRAME_TRAILER};
`endif
    end

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        grant_idx_d  = grant_idx_q;
        last_grant_d = last_grant_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        ser_out_d    = ser_out_q;
        ack_d        = '0;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    winner_d = rr_winner_c;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // A request withdrawn before its ack is cancelled.
                if (req[winner_q]) begin
                    shift_d         = frame_w_c << 1;
                    ser_out_d       = frame_w_c[FRAME_LEN-1];
                    ack_d[winner_q] = 1'b1;
                    grant_idx_d     = winner_q;
                    last_grant_d    = winner_q;
                    bit_cnt_d       = '0;
                    state_d         = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                // Registered pulse lands on the final cycle of the last bit.
                frame_done_d = pre_tick_c && (bit_cnt_q == LAST_BIT);
                if (tick_c) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        ser_out_d = 1'b0;
                        bit_cnt_d = '0;
                        if (GAP_BITS > 0) begin
                            state_d = ST_GAP;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        ser_out_d = shift_q[FRAME_LEN-1];
                        shift_d   = shift_q << 1;
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                    end
                end
            end
            ST_GAP: begin
                ser_out_d = 1'b0;
                if (tick_c) begin
                    if (bit_cnt_q == LAST_GAP) begin
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; last_grant resets so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            winner_q     <= '0;
            grant_idx_q  <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            ser_out_q    <= 1'b0;
            ack_q        <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            grant_idx_q  <= grant_idx_d;
            last_grant_q <= last_grant_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            ser_out_q    <= ser_out_d;
            ack_q        <= ack_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign ack        = ack_q;
    assign grant_idx  = grant_idx_q;
    assign busy       = busy_q;
    assign ser_out    = ser_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_phase_word_tx_sched.sv
// Directed testbench for phase_word_tx_sched: reset values, single-word frame
// timing, round-robin order with Decoder-style mid-bit decoding, mid-frame
// reset and request cancellation. Honours PHASE_TX_PARITY_EN.
module tb_phase_word_tx_sched;

    localparam int NUM_SIZE = 7;
    localparam int NUM_REQ  = 3;
    localparam int BP       = 1024;
    localparam int GAP      = 2;

`ifdef PHASE_TX_PARITY_EN
    localparam int LEN = 12;
    localparam logic [LEN-1:0] FR_36 = 12'b01_0110110_0_10;
    localparam logic [LEN-1:0] FR_00 = 12'b01_0000000_0_10;
    localparam logic [LEN-1:0] FR_3F = 12'b01_0111111_0_10;
    localparam logic [LEN-1:0] FR_7F = 12'b01_1111111_1_10;
    localparam logic [LEN-1:0] FR_55 = 12'b01_1010101_0_10;
`else
    localparam int LEN = 11;
    localparam logic [LEN-1:0] FR_36 = 11'b01_0110110_10;
    localparam logic [LEN-1:0] FR_00 = 11'b01_0000000_10;
    localparam logic [LEN-1:0] FR_3F = 11'b01_0111111_10;
    localparam logic [LEN-1:0] FR_7F = 11'b01_1111111_10;
    localparam logic [LEN-1:0] FR_55 = 11'b01_1010101_10;
`endif

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic [NUM_REQ-1:0]           req = '0;
    logic [NUM_REQ*NUM_SIZE-1:0]  req_data = '0;
    logic [NUM_REQ-1:0]           ack;
    logic [1:0]                   grant_idx;
    logic                         busy;
    logic                         ser_out;
    logic                         frame_done;

    int tests_run    = 0;
    int tests_failed = 0;

    phase_word_tx_sched #(
        .NUM_SIZE   (NUM_SIZE),
        .NUM_REQ    (NUM_REQ),
        .BIT_PERIOD (BP),
        .GAP_BITS   (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .grant_idx  (grant_idx),
        .busy       (busy),
        .ser_out    (ser_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait (bounded) for an ack; line must stay low until the ack cycle.
    task automatic wait_ack(input logic [2:0] exp_ack, input logic [1:0] exp_idx,
                            input int exp_lat, input string name);
        int n  = 0;
        int hi = 0;
        while (ack == 3'b000 && n < exp_lat + 16) begin
            if (ser_out) hi++;
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (ack !== exp_ack) begin
            tests_failed++;
            $display("FAIL %s_value: ack=%b expected %b", name, ack, exp_ack);
        end
        tests_run++;
        if (n !== exp_lat) begin
            tests_failed++;
            $display("FAIL %s_latency: %0d cycles expected %0d", name, n, exp_lat);
        end
        tests_run++;
        if (grant_idx !== exp_idx) begin
            tests_failed++;
            $display("FAIL %s_grant: grant_idx=%0d expected %0d", name, grant_idx, exp_idx);
        end
        tests_run++;
        if (hi !== 0) begin
            tests_failed++;
            $display("FAIL %s_idle_line: ser_out high %0d cycles expected 0", name, hi);
        end
    endtask

    // Called on the ack cycle (first bit); samples each bit mid-period.
    task automatic run_frame(input logic [LEN-1:0] exp_frame, input logic [6:0] exp_word,
                             input string name);
        logic [LEN-1:0] got = '0;
        logic [6:0]     num;
        int fd_cnt  = 0;
        int fd_at   = -1;
        int ack_cnt = 0;
        for (int o = 0; o < LEN*BP; o++) begin
            if (o % BP == BP/2) got[LEN-1 - o/BP] = ser_out;
            if (frame_done) begin
                fd_cnt++;
                fd_at = o;
            end
            if (o > 0 && ack !== 3'b000) ack_cnt++;
            @(negedge clk);
        end
        num = got[LEN-3 -: 7];
        tests_run++;
        if (got !== exp_frame) begin
            tests_failed++;
            $display("FAIL %s_bits: frame=%b expected %b", name, got, exp_frame);
        end
        tests_run++;
        if (num !== exp_word) begin
            tests_failed++;
            $display("FAIL %s_decode: num=%b expected %b", name, num, exp_word);
        end
        tests_run++;
        if (fd_cnt !== 1 || fd_at !== LEN*BP-1) begin
            tests_failed++;
            $display("FAIL %s_frame_done: pulses=%0d at %0d expected 1 at %0d",
                     name, fd_cnt, fd_at, LEN*BP-1);
        end
        tests_run++;
        if (ack_cnt !== 0) begin
            tests_failed++;
            $display("FAIL %s_extra_ack: %0d ack cycles expected 0", name, ack_cnt);
        end
        tests_run++;
        if (ser_out !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_gap_entry: ser_out=%b busy=%b expected 0 1", name, ser_out, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({ser_out, ack, busy, frame_done} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ser_out=%b ack=%b busy=%b frame_done=%b expected all 0",
                     ser_out, ack, busy, frame_done);
        end
        tests_run++;
        if (grant_idx !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_grant: grant_idx=%0d expected 0", grant_idx);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        req_data[6:0] = 7'b0110110;
        req = 3'b001;
        wait_ack(3'b001, 2'd0, 2, "single_ack");
        req = 3'b000;
        run_frame(FR_36, 7'b0110110, "single");
        repeat (GAP*BP - 1) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_gap_busy: busy=%b expected 1", busy);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_idle: busy=%b expected 0", busy);
        end
        tests_run++;
        if (grant_idx !== 2'd0) begin
            tests_failed++;
            $display("FAIL single_grant_hold: grant_idx=%0d expected 0", grant_idx);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_data = {7'b1111111, 7'b0111111, 7'b0000000};
        req = 3'b111;
        wait_ack(3'b001, 2'd0, 2, "rr0_ack");
        // Changing a granted word after ack must not affect the frame in flight.
        req_data[6:0] = 7'b1010101;
        run_frame(FR_00, 7'b0000000, "rr0");
        wait_ack(3'b010, 2'd1, GAP*BP + 2, "rr1_ack");
        run_frame(FR_3F, 7'b0111111, "rr1");
        wait_ack(3'b100, 2'd2, GAP*BP + 2, "rr2_ack");
        run_frame(FR_7F, 7'b1111111, "rr2");
        wait_ack(3'b001, 2'd0, GAP*BP + 2, "rr3_ack");
        run_frame(FR_55, 7'b1010101, "rr3");
    endtask

    task automatic test_reset_mid_frame();
        int bad = 0;
        req = 3'b011;
        req_data[13:7] = 7'b1111111;
        wait_ack(3'b010, 2'd1, GAP*BP + 2, "mid_ack");
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (ack !== 3'b000 || frame_done !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0 || ser_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_frame_state: stray pulses=%0d ser_out=%b expected 0 1", bad, ser_out);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({ser_out, busy, ack, frame_done} !== 6'b0) begin
            tests_failed++;
            $display("FAIL mid_abort: ser_out=%b busy=%b ack=%b frame_done=%b expected all 0",
                     ser_out, busy, ack, frame_done);
        end
        rst = 1'b0;
        wait_ack(3'b001, 2'd0, 2, "post_rst_ack");
        do_reset();
        req = 3'b000;
    endtask

    task automatic test_drop();
        int bad = 0;
        do_reset();
        req = 3'b110;
        @(negedge clk);           // LOAD for requester 1
        req = 3'b100;             // withdraw before ack
        @(negedge clk);
        tests_run++;
        if (ack !== 3'b000 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_cancel: ack=%b busy=%b expected 000 0", ack, busy);
        end
        wait_ack(3'b100, 2'd2, 2, "drop_next_ack");
        do_reset();
        req = 3'b010;
        @(negedge clk);
        req = 3'b000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack !== 3'b000 || busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL drop_stay_idle: %0d bad cycles expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_reset_mid_frame();
        test_drop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
